// File: rtl/case_conv_pkg.sv
// Shared types and constants for the case-converting character stream.
package case_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_LOWER = 2'd2,
        MODE_TITLE = 2'd3
    } conv_mode_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    localparam logic [7:0] UPPER_FIRST = 8'h41;
    localparam logic [7:0] UPPER_LAST  = 8'h5A;
    localparam logic [7:0] LOWER_FIRST = 8'h61;
    localparam logic [7:0] LOWER_LAST  = 8'h7A;
    localparam int         CASE_BIT    = 5;

    function automatic logic is_letter_byte(input logic [7:0] ch);
        return ((ch >= UPPER_FIRST) && (ch <= UPPER_LAST)) ||
               ((ch >= LOWER_FIRST) && (ch <= LOWER_LAST));
    endfunction

endpackage

// File: rtl/case_conv_lane.sv
// Combinational case conversion of one character; only the case bit ever changes.
module case_conv_lane
    import case_conv_pkg::*;
(
    input  logic [7:0] ch,
    input  conv_mode_t mode,
    input  logic       prev_letter,
    output logic [7:0] ch_conv,
    output logic       is_letter,
    output logic       changed
);

    always_comb begin
        is_letter = is_letter_byte(ch);
        ch_conv   = ch;
        if (is_letter) begin
            case (mode)
                MODE_UPPER: ch_conv[CASE_BIT] = 1'b0;
                MODE_LOWER: ch_conv[CASE_BIT] = 1'b1;
                // Title case: lower after a letter, upper after anything else.
                MODE_TITLE: ch_conv[CASE_BIT] = prev_letter;
                default:    ch_conv = ch;
            endcase
        end
        changed = (ch_conv != ch);
    end

endmodule

// File: rtl/case_conv_stream.sv
// Case-converting character stream with a 2-entry skid buffer on the output.
// Optional conv_count statistics output is enabled by defining CASE_CONV_STATS_EN.
module case_conv_stream
    import case_conv_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic [LANES-1:0]     s_keep,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*LANES-1:0]   m_data,
    output logic [LANES-1:0]     m_keep,
    output logic                 m_last,
    output skid_state_t          skid_state
`ifdef CASE_CONV_STATS_EN
    ,
    output logic [CNT_W-1:0]     conv_count
`endif
);

    // Handshake: a beat moves on a rising edge where valid and ready are both 1;
    // a source holds valid and its payload steady until that edge.
    conv_mode_t         beat_mode;
    logic               accept;
    logic               title_prev;
    logic               chain_out;
    logic [8*LANES-1:0] conv_data;
    logic [LANES-1:0]   lane_letter;
    logic [LANES-1:0]   lane_changed;
    logic [8*LANES-1:0] skid_data;
    logic [LANES-1:0]   skid_keep;
    logic               skid_last;

    assign beat_mode = conv_mode_t'(mode);
    assign accept    = s_valid & s_ready;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic       prev_in;
        logic       prev_out;
        logic [7:0] lane_out;

        if (gi == 0) begin : g_first
            assign prev_in = title_prev;
        end else begin : g_next
            assign prev_in = g_lane[gi-1].prev_out;
        end

        case_conv_lane u_lane (
            .ch          (s_data[8*gi +: 8]),
            .mode        (beat_mode),
            .prev_letter (prev_in),
            .ch_conv     (lane_out),
            .is_letter   (lane_letter[gi]),
            .changed     (lane_changed[gi])
        );

        // Dropped lanes pass through raw and are invisible to the title chain.
        assign conv_data[8*gi +: 8] = (s_keep[gi] && lane_changed[gi]) ? lane_out : s_data[8*gi +: 8];
        assign prev_out             = s_keep[gi] ? lane_letter[gi] : prev_in;
    end

    assign chain_out = g_lane[LANES-1].prev_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_state <= SKID_EMPTY;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
            title_prev <= 1'b0;
        end else begin
            if (accept) begin
                if (s_last) begin
                    title_prev <= 1'b0;
                end else if (beat_mode == MODE_TITLE) begin
                    title_prev <= chain_out;
                end
            end

            case (skid_state)
                SKID_EMPTY: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        m_valid    <= 1'b1;
                        m_data     <= conv_data;
                        m_keep     <= s_keep;
                        m_last     <= s_last;
                        skid_state <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    s_ready <= 1'b1;
                    if (accept && m_ready) begin
                        m_data <= conv_data;
                        m_keep <= s_keep;
                        m_last <= s_last;
                    end else if (accept) begin
                        skid_data  <= conv_data;
                        skid_keep  <= s_keep;
                        skid_last  <= s_last;
                        s_ready    <= 1'b0;
                        skid_state <= SKID_FULL;
                    end else if (m_ready) begin
                        m_valid    <= 1'b0;
                        skid_state <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    s_ready <= m_ready;
                    if (m_ready) begin
                        m_data     <= skid_data;
                        m_keep     <= skid_keep;
                        m_last     <= skid_last;
                        skid_state <= SKID_ONE;
                    end
                end
                default: begin
                    skid_state <= SKID_EMPTY;
                    m_valid    <= 1'b0;
                    s_ready    <= 1'b1;
                end
            endcase
        end
    end

`ifdef CASE_CONV_STATS_EN
    localparam int NW = $clog2(LANES + 1);

    logic          head_load;
    logic          head_from_skid;
    logic          skid_load;
    logic [NW-1:0] beat_changes;
    logic [NW-1:0] head_changes;
    logic [NW-1:0] skid_changes;
    logic [CNT_W:0] count_sum;

    assign head_load      = accept && ((skid_state == SKID_EMPTY) ||
                                       ((skid_state == SKID_ONE) && m_ready));
    assign skid_load      = accept && (skid_state == SKID_ONE) && !m_ready;
    assign head_from_skid = (skid_state == SKID_FULL) && m_ready;
    assign count_sum      = {1'b0, conv_count} + (CNT_W+1)'(head_changes);

    always_comb begin
        beat_changes = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_changes = beat_changes + NW'(lane_changed[i] & s_keep[i]);
        end
    end

    // Per-beat change counts travel with the beat so they are credited at emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_changes <= '0;
            skid_changes <= '0;
            conv_count   <= '0;
        end else begin
            if (head_load) begin
                head_changes <= beat_changes;
            end else if (head_from_skid) begin
                head_changes <= skid_changes;
            end
            if (skid_load) begin
                skid_changes <= beat_changes;
            end
            if (m_valid && m_ready) begin
                conv_count <= count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
            end
        end
    end
`endif

endmodule
